// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port RAM between two
// requesters, sequencing the RAM's two-cycle address/data bus protocol and
// owning the tri-state bus driver.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   reqN/weN/addrN/wdataN requester N request (level), write flag, address, data
//   ackN                  one-cycle completion pulse to requester N
//   rdata                 read data, valid with ackN on a read, held otherwise
//   busy                  high while a transaction is in flight (ADDR/DATA/DONE)
//   ram_enable, ram_rw    RAM control (rw: 1 = write)
//   bus                   shared RAM bus, driven only in ADDR and write-DATA
//   grant_cnt0/1          saturating grant counters
//
// Optional feature: define RAM_ARB_STATS_EN to build the grant counters;
// otherwise grant_cnt0/1 are tied to zero.

// Tri-state driver for the shared RAM bus.
module tri_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] data,
    inout  wire  [WIDTH-1:0] bus
);

    assign bus = oe ? data : {WIDTH{1'bz}};

endmodule

module ram_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             ack0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             ram_enable,
    output logic             ram_rw,
    inout  wire  [WIDTH-1:0] bus,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state;
    logic             last_grant;   // requester that won most recently
    logic             gnt_id;       // requester owning the current transaction
    logic             lat_we;
    logic [WIDTH-1:0] lat_wdata;
    logic             bus_oe;
    logic [WIDTH-1:0] bus_dout;

    // Round-robin winner: a lone request wins, on contention the requester
    // that did not win last time goes first.
    logic win0_c;
    logic win1_c;

    assign win0_c = req0 && (!req1 || last_grant);
    assign win1_c = req1 && (!req0 || !last_grant);

    // Transaction sequencer; outputs are loaded for the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            bus_oe     <= 1'b0;
            bus_dout   <= '0;
            ram_enable <= 1'b0;
            ram_rw     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            rdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win0_c || win1_c) begin
                        gnt_id     <= win1_c;
                        last_grant <= win1_c;
                        lat_we     <= win1_c ? we1 : we0;
                        lat_wdata  <= win1_c ? wdata1 : wdata0;
                        ram_enable <= 1'b1;
                        ram_rw     <= win1_c ? we1 : we0;
                        bus_oe     <= 1'b1;
                        bus_dout   <= win1_c ? addr1 : addr0;
                        busy       <= 1'b1;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // Reads release the bus so the RAM can drive it.
                    bus_oe   <= lat_we;
                    bus_dout <= lat_wdata;
                    state    <= ST_DATA;
                end
                ST_DATA: begin
                    ram_enable <= 1'b0;
                    bus_oe     <= 1'b0;
                    if (!lat_we) begin
                        rdata <= bus;
                    end
                    ack0  <= !gnt_id;
                    ack1  <= gnt_id;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    tri_buf #(
        .WIDTH (WIDTH)
    ) u_tri_buf (
        .oe   (bus_oe),
        .data (bus_dout),
        .bus  (bus)
    );

`ifdef RAM_ARB_STATS_EN
    // Saturating per-requester grant counters, bumped on each IDLE win.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (state == ST_IDLE) begin
            if (win0_c && (grant_cnt0 != {CNT_W{1'b1}})) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (win1_c && (grant_cnt1 != {CNT_W{1'b1}})) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural two-cycle RAM on the bus,
// directed protocol checks, fairness, mid-transaction reset, randomized rounds
// against a transaction-level model, and grant-counter saturation.
module tb_ram_arbiter;

    localparam int unsigned W       = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = 255;
`ifdef RAM_ARB_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         req0, we0, req1, we1;
    logic [W-1:0] addr0, wdata0, addr1, wdata1;
    logic         ack0, ack1, busy, ram_enable, ram_rw;
    logic [W-1:0] rdata;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
    wire  [W-1:0] bus;
    wire          bus_is_z = (bus === 8'bzzzzzzzz);

    always #5 clock = ~clock;

    ram_arbiter #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .ack0       (ack0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .ack1       (ack1),
        .rdata      (rdata),
        .busy       (busy),
        .ram_enable (ram_enable),
        .ram_rw     (ram_rw),
        .bus        (bus),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    // Behavioural RAM: address phase on the first enabled edge, data phase next.
    logic [W-1:0] mem [256];
    logic         init_mem;
    logic         ram_phase;
    logic         ram_rw_l;
    logic [W-1:0] ram_addr;
    wire          ram_drive = ram_phase && !ram_rw_l && ram_enable;

    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
            ram_phase <= 1'b0;
        end else if (ram_phase) begin
            if (ram_enable && ram_rw_l) mem[ram_addr] <= bus;
            ram_phase <= 1'b0;
        end else if (ram_enable) begin
            ram_addr  <= bus;
            ram_rw_l  <= ram_rw;
            ram_phase <= 1'b1;
        end
    end

    assign bus = ram_drive ? mem[ram_addr] : 8'bzzzzzzzz;

    // Scoreboard state
    int       n_tests, n_fail;
    bit       checks_on;
    logic [W-1:0] ref_mem [256];
    int       m_last;
    int       m_cnt [2];
    logic     rq_we [2];
    logic [W-1:0] rq_addr [2];
    logic [W-1:0] rq_wdata [2];
    int       exp_q [$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus ownership: released whenever enable is low; RAM value intact on reads.
    always @(negedge clock) begin
        if (checks_on) begin
            if (!ram_enable) check("bus_released", 16'(bus_is_z), 16'd1);
            else if (ram_drive) check("bus_read_val", 16'(bus), 16'(mem[ram_addr]));
        end
    end

    task automatic set_req(input int who, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
        rq_we[who] = we; rq_addr[who] = a; rq_wdata[who] = d;
        if (who == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else          begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    endtask

    task automatic drop(input int who);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic model_reset();
        m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    // Completes one transaction in the model; returns the data a read returns.
    task automatic model_apply(input int who, output logic [W-1:0] rd);
        rd = ref_mem[rq_addr[who]];
        if (rq_we[who]) ref_mem[rq_addr[who]] = rq_wdata[who];
        m_last = who;
        if (m_cnt[who] < CNT_MAX) m_cnt[who]++;
    endtask

    function automatic logic [15:0] exp_cnt(input int who);
        return STATS_EN ? 16'(m_cnt[who]) : 16'd0;
    endfunction

    // Wait for n acks in the order held in exp_q; 3 cycles to the first, 4 between.
    task automatic run_expect(input int n, input bit keep);
        int gap = 0;
        int done = 0;
        int who;
        logic [W-1:0] rd;
        while (done < n) begin
            @(negedge clock);
            gap++;
            if (ack0 || ack1) begin
                who = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                check("ack_who", 16'({ack1, ack0}), (who == 1) ? 16'd2 : 16'd1);
                check("ack_gap", 16'(gap), (done == 0) ? 16'd3 : 16'd4);
                check("busy_done", 16'(busy), 16'd1);
                model_apply(who, rd);
                if (!rq_we[who]) check("rdata", 16'(rdata), 16'(rd));
                if (!keep) drop(who);
                gap = 0;
                done++;
            end else if (gap > 10) begin
                check("ack_timeout", 16'(gap), 16'd4);
                drop(0); drop(1);
                exp_q.delete();
                done = n;
            end
        end
        check("cnt0", 16'(grant_cnt0), exp_cnt(0));
        check("cnt1", 16'(grant_cnt1), exp_cnt(1));
    endtask

    initial begin
        int pat;
        int first;
        n_tests = 0; n_fail = 0; checks_on = 1'b0;
        reset = 1'b1; init_mem = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        model_reset();
        repeat (3) @(negedge clock);
        init_mem = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        checks_on = 1'b1;

        // Reset state
        check("rst_enable", 16'(ram_enable), 16'd0);
        check("rst_bus_z", 16'(bus_is_z), 16'd1);
        check("rst_ack0", 16'(ack0), 16'd0);
        check("rst_ack1", 16'(ack1), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_rdata", 16'(rdata), 16'd0);
        check("rst_cnt0", 16'(grant_cnt0), 16'd0);

        // Directed write: addr 10 <- 15
        set_req(0, 1'b1, 8'd10, 8'd15);
        @(negedge clock);
        check("wr_c1_en", 16'(ram_enable), 16'd1);
        check("wr_c1_rw", 16'(ram_rw), 16'd1);
        check("wr_c1_bus", 16'(bus), 16'd10);
        @(negedge clock);
        check("wr_c2_en", 16'(ram_enable), 16'd1);
        check("wr_c2_bus", 16'(bus), 16'd15);
        @(negedge clock);
        check("wr_c3_ack0", 16'(ack0), 16'd1);
        check("wr_c3_ack1", 16'(ack1), 16'd0);
        drop(0);
        begin logic [W-1:0] rd; model_apply(0, rd); end
        @(negedge clock);
        check("wr_mem10", 16'(mem[10]), 16'd15);
        check("wr_idle_en", 16'(ram_enable), 16'd0);
        check("wr_idle_busy", 16'(busy), 16'd0);

        // Directed read by requester 1 of addr 10
        set_req(1, 1'b0, 8'd10, 8'd0);
        @(negedge clock);
        check("rd_c1_en", 16'(ram_enable), 16'd1);
        check("rd_c1_rw", 16'(ram_rw), 16'd0);
        check("rd_c1_bus", 16'(bus), 16'd10);
        check("rd_c1_ack0", 16'(ack0), 16'd0);
        @(negedge clock);
        check("rd_c2_ramdrv", 16'(ram_drive), 16'd1);
        check("rd_c2_bus", 16'(bus), 16'd15);
        check("rd_c2_ack0", 16'(ack0), 16'd0);
        @(negedge clock);
        check("rd_c3_ack1", 16'(ack1), 16'd1);
        check("rd_c3_ack0", 16'(ack0), 16'd0);
        check("rd_c3_rdata", 16'(rdata), 16'd15);
        drop(1);
        begin logic [W-1:0] rd; model_apply(1, rd); end
        @(negedge clock);
        check("rd_after_ack1", 16'(ack1), 16'd0);
        check("rd_rdata_hold", 16'(rdata), 16'd15);

        // Fairness: both held from reset
        set_req(0, 1'b1, 8'd30, 8'hA5);
        set_req(1, 1'b0, 8'd30, 8'd0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q = '{0, 1, 0, 1};
        run_expect(4, 1'b1);
        drop(0); drop(1);

        // Randomized rounds
        repeat (40) begin
            @(negedge clock);
            check("idle_busy", 16'(busy), 16'd0);
            pat = $urandom_range(1, 3);
            if (pat[0]) set_req(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            if (pat[1]) set_req(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            exp_q.delete();
            if (pat == 3) begin
                first = (m_last == 1) ? 0 : 1;
                exp_q.push_back(first);
                exp_q.push_back(1 - first);
                run_expect(2, 1'b0);
            end else begin
                exp_q.push_back((pat == 1) ? 0 : 1);
                run_expect(1, 1'b0);
            end
        end

        // Reset during the DATA phase of a write to addr 20
        @(negedge clock);
        set_req(0, 1'b1, 8'd20, 8'hEE);
        @(negedge clock);
        check("rm_addr_en", 16'(ram_enable), 16'd1);
        @(negedge clock);
        check("rm_data_bus", 16'(bus), 16'hEE);
        #2 reset = 1'b1;
        #1;
        check("rm_en_drop", 16'(ram_enable), 16'd0);
        check("rm_bus_z", 16'(bus_is_z), 16'd1);
        check("rm_no_ack", 16'(ack0), 16'd0);
        check("rm_busy", 16'(busy), 16'd0);
        drop(0);
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rm_mem_kept", 16'(mem[20]), 16'(ref_mem[20]));
        @(negedge clock);
        set_req(0, 1'b0, 8'd20, 8'd0);
        exp_q = '{0};
        run_expect(1, 1'b0);

        // 300 back-to-back requester 0 transactions
        @(negedge clock);
        set_req(0, 1'b1, 8'h40, 8'h11);
        exp_q.delete();
        for (int i = 0; i < 300; i++) exp_q.push_back(0);
        run_expect(300, 1'b1);
        drop(0);
        check("stats_cnt0", 16'(grant_cnt0), STATS_EN ? 16'd255 : 16'd0);
        check("stats_cnt1", 16'(grant_cnt1), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port `ram` and its 8-bit tristate bus between two requesters.
- Sequences the RAM's two-cycle bus protocol on each requester's behalf:
  - Cycle 1: address phase, with enable and rw driven.
  - Cycle 2: data phase; write data is driven, or read data is captured.
- Arbitration is round-robin. Sits between CPU/DMA-style masters and `ram`, and owns the bus tri-state driver.

Parameters:
- WIDTH, 8, address/data/bus width; must match `ram`.
- CNT_W, 8, width of the grant statistics counters.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 transaction request; level, held until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read; sampled at grant.
- addr0  in  WIDTH  requester 0 address; sampled at grant.
- wdata0  in  WIDTH  requester 0 write data; sampled at grant.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, we1, addr1, wdata1, ack1: same as above, for requester 1.
- rdata  out  WIDTH  read data; valid while ack0 or ack1 is high for a read; holds its value otherwise.
- busy  out  1  high in ADDR, DATA and DONE.
- ram_enable  out  1  to `ram` enable.
- ram_rw  out  1  to `ram` rw (1 = write).
- bus  inout  WIDTH  shared RAM bus; driven through an internal `tri_buf`, otherwise Z.
- grant_cnt0  out  CNT_W  transactions granted to requester 0 (see Optional Feature).
- grant_cnt1  out  CNT_W  transactions granted to requester 1.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - ram_enable=0, ram_rw=0, bus released (Z).
  - ack0=ack1=0, busy=0, rdata=0, grant counters=0.
  - last_grant=1, so requester 0 wins the first contention.
- Reset mid-transaction: the in-flight operation is abandoned with no ack. The RAM sees enable drop and returns to its own idle state. Requesters must re-issue.
- All outputs are registered, except bus, which is driven from the registered output-enable and data.
- FSM:
  - IDLE:
    - Outputs: enable=0, bus Z, acks 0.
    - If any req is high at a posedge, pick the winner:
      - Only one req high: that requester wins.
      - Both high: the requester != last_grant wins.
    - On a win: latch we, addr and wdata; update last_grant; go to ADDR.
    - Otherwise stay in IDLE.
  - ADDR:
    - ram_enable=1, ram_rw=latched we, bus driven with latched addr.
    - Go to DATA.
  - DATA:
    - ram_enable=1, ram_rw unchanged.
    - Write: bus driven with latched wdata.
    - Read: bus released (Z); the `ram` drives it. The bus is captured into rdata at the posedge ending DATA.
    - Go to DONE.
  - DONE:
    - ram_enable=0, bus Z.
    - ack of the granted requester = 1 for exactly this cycle. No arbitration here.
    - Go to IDLE.
- Latency: req seen at edge t0 → ADDR in cycle 1, DATA in cycle 2, ack in cycle 3, IDLE in cycle 4.
  - Minimum 4 cycles per transaction.
  - At least 2 cycles of enable=0 between transactions; the `ram` always starts from its idle state.
- Requester rules:
  - Hold req, we, addr and wdata stable from request until ack.
  - Drop req on the edge where ack is seen, or keep it high to request again; a request still high in IDLE is a new transaction.
  - Inputs changing after grant are ignored.
- Bus ownership: the arbiter never drives bus in IDLE, DONE or read-DATA. There is no cycle where both the arbiter and `ram` drive.
- Fairness: with both reqs held continuously, grants strictly alternate 0,1,0,1.
- A req deasserted before grant is ignored; it is illegal after grant but has no effect.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined:
  - grant_cntN increments by 1 when requester N wins in IDLE.
  - Counters saturate at 2**CNT_W-1.
  - Reset clears them.
- Undefined: grant_cnt0 and grant_cnt1 are tied to 0 and no counter logic is synthesized. The ports are present either way.

Test Plan:
- Reset with all reqs low → ram_enable=0, bus===Z, ack0=ack1=0, busy=0, rdata=0.
- req0 write, addr0=10, wdata0=15 →
  - cycle 1: enable=1, rw=1, bus=10;
  - cycle 2: bus=15;
  - cycle 3: ack0=1;
  - then ram.memory[10]===15, enable=0.
- req1 read, addr1=10 (after the previous test) → cycle 2 bus driven only by `ram`; cycle 3 ack1=1, rdata=15. ack0 stays 0 throughout.
- req0 and req1 both held high from reset for 4 transactions → grant order 0,1,0,1.
  - Each ack comes 4 cycles apart; no X/contention on bus.
- reset pulsed during DATA of a write to addr 20 → enable=0 and bus Z within the same cycle, no ack. After release, a fresh read of 20 completes normally.
- With RAM_ARB_STATS_EN: 300 back-to-back req0 transactions → grant_cnt0=255, grant_cnt1=0. Without the macro → both read 0.
